// File: rtl/clk_div_multi_if.sv
// Signal bundle for clk_div_multi: per-channel enables, reload write port,
// divided square outputs and half-period ticks.
interface clk_div_multi_if #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CW   = 32,
  parameter int unsigned WCHW = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]  en;
  logic            wr_en;
  logic [WCHW-1:0] wr_ch;
  logic [CW-1:0]   wr_data;
  logic [NCH-1:0]  clk_div;
  logic [NCH-1:0]  tick;

  modport master (
    output en, wr_en, wr_ch, wr_data,
    input  clk_div, tick
  );

  modport slave (
    input  en, wr_en, wr_ch, wr_data,
    output clk_div, tick
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator with shadowed reloads.
// Optional macro CLKDIV_SYNC_EN adds a 'sync' input that phase-aligns all channels.
module clk_div_multi #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned NCH          = 4,
  parameter int unsigned CW           = 32,
  parameter int unsigned DEFAULT_FREQ = 1
) (
  input  logic           clk,
  input  logic           rst,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  clk_div_multi_if.slave bus
);
  localparam int unsigned   WCHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] R0   = CW'(CLK_FREQ / (2 * DEFAULT_FREQ) - 1);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_act;
    logic [CW-1:0] r_shd;
    logic          r_clk_div;
    logic          r_tick;
    logic          w_wr_hit;
    logic          w_term;
    logic [CW-1:0] w_shd_nxt;

    // w_shd_nxt carries a same-cycle write so act can bypass the shadow
    always_comb begin
      w_wr_hit  = bus.wr_en && (bus.wr_ch == WCHW'(g));
      w_shd_nxt = w_wr_hit ? bus.wr_data : r_shd;
      w_term    = (r_cnt == r_act);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt     <= '0;
        r_act     <= R0;
        r_shd     <= R0;
        r_clk_div <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        r_shd <= w_shd_nxt;
`ifdef CLKDIV_SYNC_EN
        if (sync) begin
          r_cnt     <= '0;
          r_act     <= w_shd_nxt;
          r_clk_div <= 1'b0;
          r_tick    <= 1'b0;
        end else
`endif
        if (!bus.en[g]) begin
          r_cnt     <= '0;
          r_act     <= w_shd_nxt;
          r_clk_div <= 1'b0;
          r_tick    <= 1'b0;
        end else if (w_term) begin
          r_cnt     <= '0;
          r_act     <= w_shd_nxt;
          r_clk_div <= ~r_clk_div;
          r_tick    <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + CW'(1);
          r_tick <= 1'b0;
        end
      end
    end

    assign bus.clk_div[g] = r_clk_div;
    assign bus.tick[g]    = r_tick;
  end
endmodule
